// File: rtl/fpu_ctrl_pkg.sv
// Shared types and default latencies for the PSIMD FPU issue/writeback control.
// Unit-select codes, ring-entry layout and the default pipeline depths live here.
package fpu_ctrl_pkg;

   typedef enum logic [3:0] {
      ENA_NOP  = 4'b0000,
      ENA_ADD  = 4'b0001,
      ENA_MUL  = 4'b0010,
      ENA_DIV  = 4'b0011,
      ENA_SQRT = 4'b0100,
      ENA_SGNJ = 4'b0101,
      ENA_CMP  = 4'b0110,
      ENA_ITF  = 4'b0111,
      ENA_FTI  = 4'b1000,
      ENA_FMA  = 4'b1001
   } ena_e;

   localparam int DEF_ADD_LAT  = 3;
   localparam int DEF_MUL_LAT  = 4;
   localparam int DEF_FMA_LAT  = 6;
   localparam int DEF_MISC_LAT = 1;
   localparam int DEF_MAX_LAT  = 6;

   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic       we;
   } ring_entry_t;

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Decoder-to-issue handshake bundle: one decoded op per cycle, valid/ready.
interface fpu_issue_ctrl_if;

   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_ena;
   logic [4:0] in_rs1;
   logic [4:0] in_rs2;
   logic [4:0] in_rs3;
   logic [4:0] in_rd;
   logic       in_wr_enable;

   modport master (
      output in_valid, in_ena, in_rs1, in_rs2, in_rs3, in_rd, in_wr_enable,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_ena, in_rs1, in_rs2, in_rs3, in_rd, in_wr_enable,
      output in_ready
   );

endinterface

// File: rtl/fpu_scoreboard.sv
// Per-register pending bits: set on issue of a writing op, cleared on its writeback.
module fpu_scoreboard (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        set_en,
   input  logic [4:0]  set_idx,
   input  logic        clr_en,
   input  logic [4:0]  clr_idx,
   input  logic [4:0]  rd_idx_a,
   input  logic [4:0]  rd_idx_b,
   input  logic [4:0]  rd_idx_c,
   output logic        rd_a,
   output logic        rd_b,
   output logic        rd_c,
   output logic [31:0] pending
);

   logic [31:0] pend_reg;
   logic [31:0] pend_next;

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_bit
         // WAW stalls keep set and clear of one bit from ever coinciding.
         assign pend_next[gi] = (set_en && set_idx == 5'(gi)) |
                                (pend_reg[gi] & ~(clr_en && clr_idx == 5'(gi)));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg <= '0;
      end else begin
         pend_reg <= pend_next;
      end
   end

   assign rd_a    = pend_reg[rd_idx_a];
   assign rd_b    = pend_reg[rd_idx_b];
   assign rd_c    = pend_reg[rd_idx_c];
   assign pending = pend_reg;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue and writeback scheduler: hazard stalls, fixed-latency reservation ring,
// div/sqrt sequencing and arbitration of the single register-file write port.
module fpu_issue_ctrl
   import fpu_ctrl_pkg::*;
#(
   parameter int ADD_LAT  = DEF_ADD_LAT,
   parameter int MUL_LAT  = DEF_MUL_LAT,
   parameter int FMA_LAT  = DEF_FMA_LAT,
   parameter int MISC_LAT = DEF_MISC_LAT,
   parameter int MAX_LAT  = DEF_MAX_LAT
) (
   input  logic            clk,
   input  logic            rst_n,
   fpu_issue_ctrl_if.slave dec,
   output logic            issue_valid,
   output logic [3:0]      issue_ena,
   output logic            iter_start,
   output logic            iter_sqrt,
   input  logic            iter_done,
   output logic            iter_ack,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic            wb_sel_iter,
   output logic [31:0]     pending
);

   localparam int LAT_W = $clog2(MAX_LAT + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_WB   = 2'd2;

   logic [1:0]       state_reg, state_next;
   logic [4:0]       iter_rd_reg;
   logic             iter_we_reg;
   // Slot MAX_LAT is never loaded; it stays empty so any latency can index slot L.
   ring_entry_t      ring_reg  [MAX_LAT+1];
   ring_entry_t      ring_next [MAX_LAT+1];
   ring_entry_t      new_entry;

   logic             is_fixed, is_iter;
   logic [LAT_W-1:0] op_lat;
   logic             pend_rs1, pend_rs2, pend_rs3;
   logic             stall, in_ready_int, accept;
   logic             fix_issue, iter_issue, iter_wb_go, sb_set;

   always_comb begin
      is_fixed = 1'b0;
      is_iter  = 1'b0;
      op_lat   = '0;
      case (dec.in_ena)
         ENA_ADD: begin
            is_fixed = 1'b1;
            op_lat   = LAT_W'(ADD_LAT);
         end
         ENA_MUL: begin
            is_fixed = 1'b1;
            op_lat   = LAT_W'(MUL_LAT);
         end
         ENA_FMA: begin
            is_fixed = 1'b1;
            op_lat   = LAT_W'(FMA_LAT);
         end
         ENA_SGNJ, ENA_CMP, ENA_ITF, ENA_FTI: begin
            is_fixed = 1'b1;
            op_lat   = LAT_W'(MISC_LAT);
         end
         ENA_DIV, ENA_SQRT: is_iter = 1'b1;
         default: ;
      endcase
   end

   // The ring shifts before the new entry lands, so the slot that will hold it next
   // cycle is what currently sits one position higher: test slot L, load slot L-1.
   assign stall = (is_fixed | is_iter) &
                  (pend_rs1 | pend_rs2 |
                   ((dec.in_ena == ENA_FMA) & pend_rs3) |
                   (dec.in_wr_enable & pending[dec.in_rd]) |
                   (is_iter & (state_reg != ST_IDLE)) |
                   (is_fixed & ring_reg[op_lat].vld));

   assign in_ready_int = rst_n & ~stall;
   assign dec.in_ready = in_ready_int;
   assign accept       = dec.in_valid & in_ready_int;
   assign fix_issue    = accept & is_fixed;
   assign iter_issue   = accept & is_iter;
   assign sb_set       = accept & (is_fixed | is_iter) & dec.in_wr_enable;

   assign issue_valid = fix_issue;
   assign issue_ena   = fix_issue ? dec.in_ena : 4'b0000;
   assign iter_start  = iter_issue;
   assign iter_sqrt   = iter_issue & (dec.in_ena == ENA_SQRT);

   assign new_entry = '{vld: 1'b1, rd: dec.in_rd, we: dec.in_wr_enable};

   genvar gi;
   generate
      for (gi = 0; gi < MAX_LAT; gi++) begin : g_ring
         assign ring_next[gi] = (fix_issue && op_lat == LAT_W'(gi + 1)) ? new_entry
                                                                        : ring_reg[gi+1];
      end
   endgenerate
   assign ring_next[MAX_LAT] = '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= MAX_LAT; i++) begin
            ring_reg[i] <= '0;
         end
      end else begin
         ring_reg <= ring_next;
      end
   end

   // Pipeline owns the write port; the iterative result waits for an empty slot 0.
   assign iter_wb_go  = (state_reg == ST_WB) & ~ring_reg[0].vld;
   assign iter_ack    = iter_wb_go;
   assign wb_sel_iter = iter_wb_go;
   assign wb_valid    = (ring_reg[0].vld & ring_reg[0].we) | (iter_wb_go & iter_we_reg);
   assign wb_rd       = ring_reg[0].vld ? ring_reg[0].rd :
                        (iter_wb_go ? iter_rd_reg : 5'd0);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (iter_issue) state_next = ST_RUN;
         ST_RUN:  if (iter_done)  state_next = ST_WB;
         ST_WB:   if (iter_wb_go) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         iter_rd_reg <= '0;
         iter_we_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (iter_issue) begin
            iter_rd_reg <= dec.in_rd;
            iter_we_reg <= dec.in_wr_enable;
         end
      end
   end

   fpu_scoreboard u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (sb_set),
      .set_idx  (dec.in_rd),
      .clr_en   (wb_valid),
      .clr_idx  (wb_rd),
      .rd_idx_a (dec.in_rs1),
      .rd_idx_b (dec.in_rs2),
      .rd_idx_c (dec.in_rs3),
      .rd_a     (pend_rs1),
      .rd_b     (pend_rs2),
      .rd_c     (pend_rs3),
      .pending  (pending)
   );

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: hazards, ring timing, div/sqrt flow, port priority.
module tb_fpu_issue_ctrl;
   import fpu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iter_done;
   logic        issue_valid;
   logic [3:0]  issue_ena;
   logic        iter_start;
   logic        iter_sqrt;
   logic        iter_ack;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        wb_sel_iter;
   logic [31:0] pending;

   int passed = 0;
   int total  = 0;

   fpu_issue_ctrl_if dec_if ();

   fpu_issue_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .dec         (dec_if),
      .issue_valid (issue_valid),
      .issue_ena   (issue_ena),
      .iter_start  (iter_start),
      .iter_sqrt   (iter_sqrt),
      .iter_done   (iter_done),
      .iter_ack    (iter_ack),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_sel_iter (wb_sel_iter),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && dec_if.in_valid && dec_if.in_ready)
         $display("[%0t] accept ena=%b rd=%0d we=%b", $time, dec_if.in_ena, dec_if.in_rd, dec_if.in_wr_enable);
      if (wb_valid)
         $display("[%0t] writeback rd=%0d sel_iter=%b ack=%b", $time, wb_rd, wb_sel_iter, iter_ack);
   end

   task automatic drive(input logic [3:0] ena, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rs3, input logic [4:0] rd, input logic we);
      dec_if.in_valid     = 1'b1;
      dec_if.in_ena       = ena;
      dec_if.in_rs1       = rs1;
      dec_if.in_rs2       = rs2;
      dec_if.in_rs3       = rs3;
      dec_if.in_rd        = rd;
      dec_if.in_wr_enable = we;
   endtask

   task automatic idle();
      dec_if.in_valid     = 1'b0;
      dec_if.in_ena       = 4'b0000;
      dec_if.in_rs1       = 5'd0;
      dec_if.in_rs2       = 5'd0;
      dec_if.in_rs3       = 5'd0;
      dec_if.in_rd        = 5'd0;
      dec_if.in_wr_enable = 1'b0;
   endtask

   // Inputs change at posedge+1; outputs are sampled at the following negedge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      #4;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      iter_done = 1'b0;
      drive(ENA_ADD, 5'd1, 5'd2, 5'd0, 5'd5, 1'b1);
      @(negedge clk);
      total++; if (dec_if.in_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", dec_if.in_ready); else passed++;
      total++; if (issue_valid !== 1'b0 || iter_start !== 1'b0) $display("FAIL reset_issue got valid=%b start=%b want 0 0", issue_valid, iter_start); else passed++;
      total++; if (pending !== 32'h0 || wb_valid !== 1'b0 || iter_ack !== 1'b0) $display("FAIL reset_state got pend=%h wb=%b ack=%b want 0 0 0", pending, wb_valid, iter_ack); else passed++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();
      sample();
      total++; if (dec_if.in_ready !== 1'b1 || pending !== 32'h0) $display("FAIL reset_release got ready=%b pend=%h want 1 0", dec_if.in_ready, pending); else passed++;
      next_cycle();
   endtask

   task automatic test_add_latency();
      drive(ENA_ADD, 5'd1, 5'd2, 5'd0, 5'd5, 1'b1);
      sample();
      total++; if (dec_if.in_ready !== 1'b1 || issue_valid !== 1'b1 || issue_ena !== 4'b0001) $display("FAIL add_issue got ready=%b valid=%b ena=%b want 1 1 0001", dec_if.in_ready, issue_valid, issue_ena); else passed++;
      next_cycle();
      idle();
      for (int k = 1; k <= 4; k++) begin
         sample();
         total++; if (wb_valid !== (k == 3) || (k == 3 && (wb_rd !== 5'd5 || wb_sel_iter !== 1'b0))) $display("FAIL add_wb k=%0d got wb=%b rd=%0d sel=%b want wb=%b rd=5 sel=0", k, wb_valid, wb_rd, wb_sel_iter, k == 3); else passed++;
         total++; if (pending[5] !== (k <= 3)) $display("FAIL add_pending k=%0d got %b want %b", k, pending[5], k <= 3); else passed++;
         next_cycle();
      end
   endtask

   task automatic test_raw_stall();
      drive(ENA_MUL, 5'd1, 5'd2, 5'd0, 5'd3, 1'b1);
      sample();
      total++; if (issue_valid !== 1'b1 || issue_ena !== 4'b0010) $display("FAIL mul_issue got valid=%b ena=%b want 1 0010", issue_valid, issue_ena); else passed++;
      next_cycle();
      drive(ENA_ADD, 5'd3, 5'd4, 5'd0, 5'd6, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         sample();
         if (k <= 5) begin
            total++; if (dec_if.in_ready !== (k == 5) || issue_valid !== (k == 5)) $display("FAIL raw_stall k=%0d got ready=%b valid=%b want %b", k, dec_if.in_ready, issue_valid, k == 5); else passed++;
         end
         total++; if (wb_valid !== (k == 4 || k == 8) || (k == 4 && wb_rd !== 5'd3) || (k == 8 && wb_rd !== 5'd6)) $display("FAIL raw_wb k=%0d got wb=%b rd=%0d want wb=%b rd=%0d", k, wb_valid, wb_rd, k == 4 || k == 8, (k == 4) ? 3 : 6); else passed++;
         next_cycle();
         if (k == 5) idle();
      end
   endtask

   task automatic test_hazards_nop();
      drive(ENA_MUL, 5'd1, 5'd2, 5'd0, 5'd12, 1'b1);
      sample();
      total++; if (issue_valid !== 1'b1) $display("FAIL hz_mul got valid=%b want 1", issue_valid); else passed++;
      next_cycle();
      drive(ENA_SGNJ, 5'd1, 5'd2, 5'd12, 5'd13, 1'b1);
      sample();
      total++; if (dec_if.in_ready !== 1'b1) $display("FAIL hz_rs3_ignored got ready=%b want 1", dec_if.in_ready); else passed++;
      next_cycle();
      drive(ENA_FMA, 5'd1, 5'd2, 5'd12, 5'd14, 1'b1);
      sample();
      total++; if (dec_if.in_ready !== 1'b0 || issue_valid !== 1'b0) $display("FAIL hz_fma_rs3 got ready=%b valid=%b want 0 0", dec_if.in_ready, issue_valid); else passed++;
      total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd13) $display("FAIL hz_misc_wb got wb=%b rd=%0d want 1 13", wb_valid, wb_rd); else passed++;
      next_cycle();
      drive(ENA_ADD, 5'd1, 5'd2, 5'd0, 5'd12, 1'b1);
      sample();
      total++; if (dec_if.in_ready !== 1'b0) $display("FAIL hz_waw got ready=%b want 0", dec_if.in_ready); else passed++;
      next_cycle();
      drive(4'b0000, 5'd12, 5'd12, 5'd0, 5'd20, 1'b1);
      sample();
      total++; if (dec_if.in_ready !== 1'b1 || issue_valid !== 1'b0 || iter_start !== 1'b0) $display("FAIL hz_nop got ready=%b valid=%b start=%b want 1 0 0", dec_if.in_ready, issue_valid, iter_start); else passed++;
      total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd12) $display("FAIL hz_mul_wb got wb=%b rd=%0d want 1 12", wb_valid, wb_rd); else passed++;
      next_cycle();
      drive(4'b1111, 5'd1, 5'd2, 5'd0, 5'd21, 1'b1);
      sample();
      total++; if (dec_if.in_ready !== 1'b1 || issue_valid !== 1'b0) $display("FAIL hz_undef got ready=%b valid=%b want 1 0", dec_if.in_ready, issue_valid); else passed++;
      total++; if (pending !== 32'h0) $display("FAIL hz_nop_pend got %h want 0", pending); else passed++;
      next_cycle();
      idle();
      sample();
      total++; if (pending !== 32'h0) $display("FAIL hz_undef_pend got %h want 0", pending); else passed++;
      next_cycle();
   endtask

   task automatic test_iter_busy();
      drive(ENA_DIV, 5'd1, 5'd2, 5'd0, 5'd7, 1'b1);
      sample();
      total++; if (iter_start !== 1'b1 || iter_sqrt !== 1'b0 || issue_valid !== 1'b0) $display("FAIL div_start got start=%b sqrt=%b valid=%b want 1 0 0", iter_start, iter_sqrt, issue_valid); else passed++;
      next_cycle();
      drive(ENA_SQRT, 5'd9, 5'd10, 5'd0, 5'd8, 1'b1);
      for (int k = 1; k <= 21; k++) begin
         if (k == 20) iter_done = 1'b1;
         sample();
         total++; if (dec_if.in_ready !== 1'b0 || iter_start !== 1'b0) $display("FAIL iter_busy k=%0d got ready=%b start=%b want 0 0", k, dec_if.in_ready, iter_start); else passed++;
         if (k == 1) begin
            total++; if (pending[7] !== 1'b1) $display("FAIL div_pending got %b want 1", pending[7]); else passed++;
         end
         total++; if (wb_valid !== (k == 21) || iter_ack !== (k == 21) || (k == 21 && (wb_rd !== 5'd7 || wb_sel_iter !== 1'b1))) $display("FAIL div_wb k=%0d got wb=%b ack=%b rd=%0d sel=%b want %b", k, wb_valid, iter_ack, wb_rd, wb_sel_iter, k == 21); else passed++;
         next_cycle();
      end
      iter_done = 1'b0;
      sample();
      total++; if (dec_if.in_ready !== 1'b1 || iter_start !== 1'b1 || iter_sqrt !== 1'b1) $display("FAIL sqrt_start got ready=%b start=%b sqrt=%b want 1 1 1", dec_if.in_ready, iter_start, iter_sqrt); else passed++;
      total++; if (pending[7] !== 1'b0) $display("FAIL div_clear got %b want 0", pending[7]); else passed++;
      next_cycle();
      idle();
      for (int k = 23; k <= 26; k++) begin
         if (k == 25) iter_done = 1'b1;
         sample();
         total++; if (iter_ack !== (k == 26) || wb_valid !== (k == 26) || (k == 26 && (wb_rd !== 5'd8 || wb_sel_iter !== 1'b1))) $display("FAIL sqrt_wb k=%0d got wb=%b ack=%b rd=%0d want %b rd=8", k, wb_valid, iter_ack, wb_rd, k == 26); else passed++;
         next_cycle();
      end
      iter_done = 1'b0;
   endtask

   task automatic test_wb_priority();
      for (int v = 0; v < 2; v++) begin
         int done_k;
         done_k = 4 - v;
         drive(ENA_DIV, 5'd1, 5'd2, 5'd0, 5'd7, 1'b1);
         sample();
         total++; if (iter_start !== 1'b1) $display("FAIL prio_div_start v=%0d got %b want 1", v, iter_start); else passed++;
         next_cycle();
         drive(ENA_ADD, 5'd1, 5'd3, 5'd0, 5'd2, 1'b1);
         sample();
         total++; if (issue_valid !== 1'b1) $display("FAIL prio_add_issue v=%0d got %b want 1", v, issue_valid); else passed++;
         next_cycle();
         idle();
         for (int k = 2; k <= 6; k++) begin
            if (k == done_k) iter_done = 1'b1;
            if (k == 6) iter_done = 1'b0;
            sample();
            if (k == 4) begin
               total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_sel_iter !== 1'b0 || iter_ack !== 1'b0) $display("FAIL prio_pipe v=%0d got wb=%b rd=%0d sel=%b ack=%b want 1 2 0 0", v, wb_valid, wb_rd, wb_sel_iter, iter_ack); else passed++;
            end else if (k == 5) begin
               total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_sel_iter !== 1'b1 || iter_ack !== 1'b1) $display("FAIL prio_iter v=%0d got wb=%b rd=%0d sel=%b ack=%b want 1 7 1 1", v, wb_valid, wb_rd, wb_sel_iter, iter_ack); else passed++;
            end else begin
               total++; if (wb_valid !== 1'b0 || iter_ack !== 1'b0) $display("FAIL prio_quiet v=%0d k=%0d got wb=%b ack=%b want 0 0", v, k, wb_valid, iter_ack); else passed++;
            end
            next_cycle();
         end
      end
   endtask

   task automatic test_fma_slot();
      drive(ENA_FMA, 5'd1, 5'd2, 5'd3, 5'd10, 1'b1);
      sample();
      total++; if (issue_valid !== 1'b1 || issue_ena !== 4'b1001) $display("FAIL fma_issue got valid=%b ena=%b want 1 1001", issue_valid, issue_ena); else passed++;
      next_cycle();
      idle();
      for (int k = 1; k <= 8; k++) begin
         if (k == 3) drive(ENA_ADD, 5'd4, 5'd5, 5'd0, 5'd11, 1'b1);
         sample();
         if (k == 3) begin
            total++; if (dec_if.in_ready !== 1'b0 || issue_valid !== 1'b0) $display("FAIL slot_stall got ready=%b valid=%b want 0 0", dec_if.in_ready, issue_valid); else passed++;
         end
         if (k == 4) begin
            total++; if (dec_if.in_ready !== 1'b1 || issue_valid !== 1'b1) $display("FAIL slot_accept got ready=%b valid=%b want 1 1", dec_if.in_ready, issue_valid); else passed++;
         end
         total++; if (wb_valid !== (k == 6 || k == 7) || (k == 6 && wb_rd !== 5'd10) || (k == 7 && wb_rd !== 5'd11)) $display("FAIL slot_wb k=%0d got wb=%b rd=%0d want wb=%b rd=%0d", k, wb_valid, wb_rd, k == 6 || k == 7, (k == 6) ? 10 : 11); else passed++;
         next_cycle();
         if (k == 4) idle();
      end
   endtask

   task automatic test_reset_mid();
      drive(ENA_ADD, 5'd1, 5'd2, 5'd0, 5'd5, 1'b1);
      sample();
      total++; if (issue_valid !== 1'b1) $display("FAIL mid_issue got %b want 1", issue_valid); else passed++;
      next_cycle();
      idle();
      rst_n = 1'b0;
      sample();
      total++; if (pending !== 32'h0) $display("FAIL mid_pending got %h want 0", pending); else passed++;
      next_cycle();
      rst_n = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         sample();
         total++; if (wb_valid !== 1'b0) $display("FAIL mid_dropped k=%0d got wb=%b want 0", k, wb_valid); else passed++;
         next_cycle();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      test_reset();
      test_add_latency();
      test_raw_stall();
      test_hazards_nop();
      test_iter_busy();
      test_wb_priority();
      test_fma_slot();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
- Issue and writeback scheduler for the PSIMD floating-point unit. Sits between the instruction decoder and the functional units.
- Accepts one decoded op per cycle and stalls on RAW/WAW hazards, iterative-unit busy, and writeback-slot conflicts.
- Dispatches fixed-latency ops (add/sub, mul, fma/fms, misc) and iterative ops (div, sqrt), then sequences the single shared register-file write port.

Parameters:
- ADD_LAT, 3, cycles from issue to writeback for ena=0001.
- MUL_LAT, 4, latency for ena=0010.
- FMA_LAT, 6, latency for ena=1001.
- MISC_LAT, 1, latency for ena=0101/0110/0111/1000.
- MAX_LAT, 6, reservation-ring depth; must be >= every *_LAT.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded op present
- in_ready  out  1  op accepted this cycle when in_valid & in_ready
- in_ena  in  4  unit select code from decoder
- in_rs1  in  5  source 1
- in_rs2  in  5  source 2
- in_rs3  in  5  source 3; used only when in_ena=1001
- in_rd  in  5  destination
- in_wr_enable  in  1  op writes rd
- issue_valid  out  1  one-cycle dispatch strobe to fixed-latency units
- issue_ena  out  4  unit code of the dispatched op
- iter_start  out  1  one-cycle start pulse to the div/sqrt unit
- iter_sqrt  out  1  qualifies iter_start: 1=sqrt, 0=div
- iter_done  in  1  iterative result ready; held high until iter_ack
- iter_ack  out  1  iterative result written this cycle
- wb_valid  out  1  register-file write strobe
- wb_rd  out  5  write address
- wb_sel_iter  out  1  write-data mux: 1=iterative unit, 0=pipeline
- pending  out  32  scoreboard (debug/verification)

Behaviour:
- Reset (async, rst_n=0): scoreboard, reservation ring and FSM cleared; every registered output 0; in_ready forced 0.
- Op classes:
  - ena 0001/0010/1001/0101–1000 are fixed-latency with L from the parameters.
  - ena 0011 (div) and 0100 (sqrt) are iterative.
  - ena 0000 and undefined codes are NOPs: accepted when in_valid, no dispatch, no scoreboard effect.
- Hazard stall: in_ready=0 if any of the following holds.
  - pending[rs1] or pending[rs2], or pending[rs3] when ena=1001.
  - pending[rd] when in_wr_enable (WAW).
  - Iterative op while iter FSM is not IDLE.
  - Fixed op whose reservation slot L-1 is occupied.
- No bypass: a register written back in cycle t is readable by an op issued at t+1, not t.
- Fixed issue at accept cycle t:
  - issue_valid/issue_ena are combinational in cycle t.
  - Ring slot L-1 loaded with {1,rd,wr_enable}; the ring shifts toward slot 0 every cycle.
  - Slot 0 drives writeback in cycle t+L: wb_valid=wr_enable, wb_rd=rd, wb_sel_iter=0.
- Scoreboard: bit set at accept when wr_enable=1, cleared in the cycle wb_valid fires for that rd. Set and clear of the same bit cannot coincide, because WAW stalls.
- Iter FSM:
  - IDLE: on accept of div/sqrt, pulse iter_start, latch rd/wr_enable, go to RUN.
  - RUN: wait for iter_done, then go to WB.
  - WB: if ring slot 0 is empty this cycle, write back with wb_sel_iter=1 and pulse iter_ack, then go to IDLE. Otherwise stay in WB; the pipeline has priority.
  - A wr_enable=0 iterative op still waits for iter_done and acks without wb_valid.
- At most one write per cycle, guaranteed by slot-0 priority.
- Reset mid-operation: all in-flight ops are dropped. Units are reset by the same rst_n.

Decomposition:
- Shared package fpu_ctrl_pkg:
  - Enum of ena codes (ENA_ADD, ENA_MUL, ENA_DIV, ENA_SQRT, ENA_SGNJ, ENA_CMP, ENA_ITF, ENA_FTI, ENA_FMA).
  - Default latency constants.
  - Ring-entry struct {vld, rd, we}.
- One sub-module fpu_scoreboard: 32-bit pending vector with set/clear ports and three read ports.

Test Plan:
- add rd=5 accepted at cycle 10 -> issue_valid@10; wb_valid, wb_rd=5, wb_sel_iter=0 @13; pending[5] high during cycles 11–13, low at 14.
- mul rd=3 then add rs1=3 on the next cycle -> add stalled until cycle t+4 (mul writes at t+4), then accepted at t+5.
- div rd=7, iter_done raised 20 cycles later -> iter_start pulse, then wb_rd=7 with iter_ack on the first cycle slot 0 is free.
- Second div issued while the first is still in RUN -> in_ready=0 until the FSM returns to IDLE.
- iter_done in the same cycle slot 0 holds add rd=2 -> wb_rd=2 first, iterative write one cycle later.
- fma issued at t, then add issued at t+3 -> both target writeback at t+6, so the add is stalled one cycle and writes at t+7.
